// File: rtl/fp_operand_sort.sv
// Two-stage operand unpack and magnitude sort ahead of a floating-point adder.
// Stage 1 unpacks and flushes denormals; stage 2 compares, swaps and flags specials.
module fp_operand_sort (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        comp,
    output logic        a_sign,
    output logic        b_sign,
    output logic [7:0]  big_exp,
    output logic [7:0]  small_exp,
    output logic [23:0] big_man,
    output logic [23:0] small_man,
    output logic        zero_out,
    output logic        inf_out,
    output logic        nan_out
);

    logic        s1_valid;
    logic        s1_a_sign, s1_b_sign;
    logic [7:0]  s1_a_exp, s1_b_exp;
    logic [23:0] s1_a_man, s1_b_man;
    logic        s1_a_inf, s1_a_nan, s1_b_inf, s1_b_nan;

    logic        s2_ready;
    logic        s1_advance;
    logic        in_fire;

    logic [7:0]  u_a_exp, u_b_exp;
    logic [23:0] u_a_man, u_b_man;
    logic        a_ge_b;
    logic        nan_next;

    assign s2_ready   = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign in_fire    = in_valid && in_ready;

    // Denormals and zeros flush to an all-zero exponent/mantissa pair.
    always_comb begin
        u_a_exp = a[30:23];
        u_b_exp = b[30:23];
        u_a_man = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        u_b_man = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    end

    // NOTE: data registers take the async reset too, because the outputs must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_a_exp  <= 8'd0;
            s1_b_exp  <= 8'd0;
            s1_a_man  <= 24'd0;
            s1_b_man  <= 24'd0;
            s1_a_inf  <= 1'b0;
            s1_a_nan  <= 1'b0;
            s1_b_inf  <= 1'b0;
            s1_b_nan  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_a_sign <= a[31];
                s1_b_sign <= b[31] ^ sub;
                s1_a_exp  <= u_a_exp;
                s1_b_exp  <= u_b_exp;
                s1_a_man  <= u_a_man;
                s1_b_man  <= u_b_man;
                s1_a_inf  <= (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
                s1_a_nan  <= (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
                s1_b_inf  <= (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
                s1_b_nan  <= (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
            end
        end
    end

    assign a_ge_b   = {s1_a_exp, s1_a_man} >= {s1_b_exp, s1_b_man};
    // Opposite-signed infinities meeting in the adder give an invalid result.
    assign nan_next = s1_a_nan || s1_b_nan ||
                      (s1_a_inf && s1_b_inf && (s1_a_sign != s1_b_sign));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            comp      <= 1'b0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            big_exp   <= 8'd0;
            small_exp <= 8'd0;
            big_man   <= 24'd0;
            small_man <= 24'd0;
            zero_out  <= 1'b0;
            inf_out   <= 1'b0;
            nan_out   <= 1'b0;
        end else begin
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s1_advance) begin
                comp      <= a_ge_b;
                a_sign    <= s1_a_sign;
                b_sign    <= s1_b_sign;
                big_exp   <= a_ge_b ? s1_a_exp : s1_b_exp;
                small_exp <= a_ge_b ? s1_b_exp : s1_a_exp;
                big_man   <= a_ge_b ? s1_a_man : s1_b_man;
                small_man <= a_ge_b ? s1_b_man : s1_a_man;
                zero_out  <= (s1_a_exp == 8'd0) && (s1_b_exp == 8'd0);
                inf_out   <= (s1_a_inf || s1_b_inf) && !nan_next;
                nan_out   <= nan_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_operand_sort.sv
// Self-checking bench for fp_operand_sort: directed vectors, backpressure, reset and
// a randomized stream scored against an arithmetic reference model.
module tb_fp_operand_sort;

    typedef struct packed {
        logic        comp;
        logic        a_sign;
        logic        b_sign;
        logic [7:0]  big_exp;
        logic [7:0]  small_exp;
        logic [23:0] big_man;
        logic [23:0] small_man;
        logic        zero;
        logic        inf;
        logic        nan;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        comp, a_sign, b_sign;
    logic [7:0]  big_exp, small_exp;
    logic [23:0] big_man, small_man;
    logic        zero_out, inf_out, nan_out;

    int n_cmp = 0;
    int n_fail = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    fp_operand_sort dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .comp(comp), .a_sign(a_sign), .b_sign(b_sign),
        .big_exp(big_exp), .small_exp(small_exp),
        .big_man(big_man), .small_man(small_man),
        .zero_out(zero_out), .inf_out(inf_out), .nan_out(nan_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic res_t dut_res();
        res_t r;
        r = '{comp, a_sign, b_sign, big_exp, small_exp, big_man, small_man,
              zero_out, inf_out, nan_out};
        return r;
    endfunction

    // Reference: magnitudes as plain integers, specials classified from the raw fields.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        res_t r;
        longint xe, ye, xm, ym, xmag, ymag;
        bit x_inf, x_nan, y_inf, y_nan, ys;
        xe = longint'(x[30:23]);
        ye = longint'(y[30:23]);
        xm = (xe == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
        ym = (ye == 0) ? 0 : (longint'(1) << 23) + longint'(y[22:0]);
        xmag = xe * 16777216 + xm;
        ymag = ye * 16777216 + ym;
        x_inf = (xe == 255) && (x[22:0] == 0);
        x_nan = (xe == 255) && (x[22:0] != 0);
        y_inf = (ye == 255) && (y[22:0] == 0);
        y_nan = (ye == 255) && (y[22:0] != 0);
        ys = y[31] ^ s;
        r.comp   = (xmag >= ymag);
        r.a_sign = x[31];
        r.b_sign = ys;
        r.big_exp   = r.comp ? 8'(xe) : 8'(ye);
        r.small_exp = r.comp ? 8'(ye) : 8'(xe);
        r.big_man   = r.comp ? 24'(xm) : 24'(ym);
        r.small_man = r.comp ? 24'(ym) : 24'(xm);
        r.nan  = x_nan || y_nan || (x_inf && y_inf && (x[31] != ys));
        r.inf  = (x_inf || y_inf) && !r.nan;
        r.zero = (xe == 0) && (ye == 0);
        return r;
    endfunction

    task automatic compare_out(input res_t got, input res_t req);
        check("comp",      got.comp,      req.comp);
        check("a_sign",    got.a_sign,    req.a_sign);
        check("b_sign",    got.b_sign,    req.b_sign);
        check("big_exp",   got.big_exp,   req.big_exp);
        check("small_exp", got.small_exp, req.small_exp);
        check("big_man",   got.big_man,   req.big_man);
        check("small_man", got.small_man, req.small_man);
        check("zero_out",  got.zero,      req.zero);
        check("inf_out",   got.inf,       req.inf);
        check("nan_out",   got.nan,       req.nan);
    endtask

    // One clock: drive at the falling edge, score transfers, advance to the next falling edge.
    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic ordy, input res_t req,
                         output logic accepted);
        res_t e;
        in_valid = iv; a = ia; b = ib; sub = isub; out_ready = ordy;
        #1;
        accepted = iv && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                compare_out(dut_res(), e);
            end
        end
        if (accepted) exp_q.push_back(req);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        logic acc;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) v[30:23] = 8'h00;
        if (k == 1) v[30:23] = 8'hFF;
        if (k == 2) begin v[30:23] = 8'hFF; v[22:0] = '0; end
        if (k == 3) v[30:0] = '0;
        if (k == 4) v[30:23] = 8'h7F;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        logic acc;
        res_t snap;
        int guard;
        logic [31:0] ra, rb;
        logic rs;

        //        comp as bs big_e  sml_e  big_m      sml_m      z  i  n
        vecs[0] = '{32'h40400000, 32'h3F800000, 1'b0,
                    '{1, 0, 0, 8'h80, 8'h7F, 24'hC00000, 24'h800000, 0, 0, 0}};
        vecs[1] = '{32'h3F800000, 32'h40400000, 1'b0,
                    '{0, 0, 0, 8'h80, 8'h7F, 24'hC00000, 24'h800000, 0, 0, 0}};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b1,
                    '{1, 0, 1, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 0, 0, 0}};
        vecs[3] = '{32'h7F800000, 32'hFF800000, 1'b0,
                    '{1, 0, 1, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 0, 0, 1}};
        vecs[4] = '{32'h00000001, 32'h80000000, 1'b0,
                    '{1, 0, 1, 8'h00, 8'h00, 24'h000000, 24'h000000, 1, 0, 0}};
        vecs[5] = '{32'h7F800000, 32'h3F800000, 1'b0,
                    '{1, 0, 0, 8'hFF, 8'h7F, 24'h800000, 24'h800000, 0, 1, 0}};
        vecs[6] = '{32'h00000000, 32'h7FC00000, 1'b0,
                    '{0, 0, 0, 8'hFF, 8'h00, 24'hC00000, 24'h000000, 0, 0, 1}};
        vecs[7] = '{32'h7F800000, 32'h7F800000, 1'b1,
                    '{1, 0, 1, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 0, 0, 1}};

        // Reset state.
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", dut_res(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed vectors, back to back, plus latency check on the first one.
        cycle(1'b1, vecs[0].a, vecs[0].b, vecs[0].sub, 1'b1, vecs[0].exp, acc);
        check("first_accept", acc, 1);
        #1 check("latency_1cycle_no_valid", out_valid, 0);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].exp, acc);
            check("vec_accept", acc, 1);
        end
        drain(10);

        // Backpressure: two accepted, third refused, outputs hold, then in-order drain.
        cycle(1'b1, 32'h40000000, 32'h3F000000, 1'b0, 1'b0, model(32'h40000000, 32'h3F000000, 1'b0), acc);
        check("bp_accept1", acc, 1);
        cycle(1'b1, 32'hC1200000, 32'h41200000, 1'b1, 1'b0, model(32'hC1200000, 32'h41200000, 1'b1), acc);
        check("bp_accept2", acc, 1);
        cycle(1'b1, 32'h3E800000, 32'h42000000, 1'b0, 1'b0, model(32'h3E800000, 32'h42000000, 1'b0), acc);
        check("bp_refuse3", acc, 0);
        check("bp_out_valid", out_valid, 1);
        snap = dut_res();
        cycle(1'b1, 32'h3E800000, 32'h42000000, 1'b0, 1'b0, model(32'h3E800000, 32'h42000000, 1'b0), acc);
        check("bp_still_refused", acc, 0);
        check("bp_hold", dut_res(), snap);
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 5) begin
            cycle(1'b1, 32'h3E800000, 32'h42000000, 1'b0, 1'b1, model(32'h3E800000, 32'h42000000, 1'b0), acc);
            guard++;
        end
        check("bp_third_accepted", acc, 1);
        drain(10);

        // Reset while outputs are valid.
        cycle(1'b1, 32'h40A00000, 32'h40400000, 1'b0, 1'b0, model(32'h40A00000, 32'h40400000, 1'b0), acc);
        cycle(1'b1, 32'h3F800000, 32'h40400000, 1'b0, 1'b0, model(32'h3F800000, 32'h40400000, 1'b0), acc);
        check("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_outputs", dut_res(), '0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
            check("rst_no_output", out_valid, 0);
        end

        // Randomized stream with random valid/ready.
        for (int i = 0; i < 400; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            rs = 1'($urandom);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 20) begin
                cycle(($urandom_range(0, 3) != 0), ra, rb, rs, ($urandom_range(0, 3) != 0),
                      model(ra, rb, rs), acc);
                guard++;
            end
            if (!acc) check("rand_accept_timeout", 0, 1);
        end
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_operand_sort.md
FP_OPERAND_SORT -- requirements
Module: fp_operand_sort

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have `rst_n`, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The block SHALL have `in_valid`, input, 1 bit: operand pair on `a`, `b`, `sub` is valid.
REQ-004 The block SHALL have `in_ready`, output, 1 bit: block accepts the pair this cycle.
REQ-005 The block SHALL have `a` and `b`, input, 32 bits each: IEEE-754 single operands.
REQ-006 The block SHALL have `sub`, input, 1 bit: 1 selects A-B, 0 selects A+B.
REQ-007 The block SHALL have `out_valid`, output, 1 bit: sorted pair present on the outputs.
REQ-008 The block SHALL have `out_ready`, input, 1 bit: downstream adder consumes the pair this cycle.
REQ-009 The block SHALL have `comp`, output, 1 bit: 1 when |A| >= |B|.
REQ-010 The block SHALL have `a_sign`, output, 1 bit: sign of A.
REQ-011 The block SHALL have `b_sign`, output, 1 bit: effective sign of B.
REQ-012 The block SHALL have `big_exp` and `small_exp`, output, 8 bits each: exponents of the larger and smaller magnitude.
REQ-013 The block SHALL have `big_man` and `small_man`, output, 24 bits each: mantissas with the hidden bit at bit 23.
REQ-014 The block SHALL have `zero_out`, `inf_out` and `nan_out`, output, 1 bit each: special-case flags.

Function
REQ-015 The block SHALL be a 2-stage pipeline: S1 unpack register, S2 compare/swap register; all outputs SHALL be driven from S2 registers.
REQ-016 A transfer SHALL occur on a rising edge with valid=1 and ready=1 on that port; latency from input transfer to `out_valid`=1 SHALL be 2 cycles when not stalled.
REQ-017 An S-stage SHALL load when it is empty or its contents transfer out in the same cycle; `in_ready` = !S1_valid | S1_advance, with no combinational path from `in_valid` to `in_ready`.
REQ-018 Throughput SHALL be one pair per cycle with `out_ready` held high; total capacity SHALL be 2 pairs.
REQ-019 While `out_valid`=1 and `out_ready`=0, all outputs SHALL hold stable.
REQ-020 S1 unpack: when exp==0 (zero or denormal), exp SHALL be 0 and man SHALL be 0 (flush-to-zero); otherwise man = {1, frac[22:0]}.
REQ-021 S1 effective B sign SHALL be b[31] XOR `sub`; `a_sign` SHALL be a[31].
REQ-022 S2 magnitude compare SHALL use {exp, man} as a 32-bit unsigned value; `comp`=1 when A >= B, so ties give `comp`=1.
REQ-023 When `comp`=1, `big_*` SHALL come from A and `small_*` from B; otherwise they SHALL be swapped; sign outputs SHALL never be swapped.
REQ-024 An operand with exp==255 SHALL be infinite if frac==0, else NaN.
REQ-025 `nan_out` SHALL be 1 when either operand is NaN, or both are infinite with `a_sign` != `b_sign`.
REQ-026 `inf_out` SHALL be 1 when either operand is infinite and `nan_out`=0.
REQ-027 `zero_out` SHALL be 1 when both flushed operands are zero and they are not NaN or infinite.
REQ-028 Flags SHALL share the same pipeline timing as the data; mantissa and exponent outputs SHALL still follow REQ-020..023 when flags are set.
REQ-029 Simultaneous input and output transfers with both stages full SHALL move both stages in the same cycle without loss or duplication.

Reset
REQ-030 `rst_n`=0 SHALL asynchronously clear the S1/S2 valid bits, so `out_valid`=0 and `in_ready`=1 once reset is released.
REQ-031 `rst_n`=0 SHALL asynchronously clear all data and flag outputs to 0.
REQ-032 Any pair in flight when reset asserts SHALL be discarded, and no output transfer SHALL occur until a new input is accepted.
REQ-033 The first input SHALL be accepted on the first rising edge with `rst_n`=1.

Verification
REQ-034 Basic sort: a=0x40400000, b=0x3F800000, sub=0, out_ready=1 -> two cycles later `comp`=1, `big_exp`=0x80, `small_exp`=0x7F, `big_man`=0xC00000, `small_man`=0x800000, `b_sign`=0.
REQ-035 Swap and tie: a=0x3F800000, b=0x40400000 -> `comp`=0 and `big_man`=0xC00000; then a=b=0x3F800000, sub=1 -> `comp`=1 and `b_sign`=1.
REQ-036 Backpressure: out_ready=0 with 3 back-to-back inputs -> 2 accepted and `in_ready`=0 on the third; on out_ready=1, outputs drain in order with no loss.
REQ-037 Specials: a=0x7F800000, b=0xFF800000, sub=0 -> `nan_out`=1; a=0x00000001, b=0x80000000 -> `zero_out`=1 and both mantissas 0.
REQ-038 Reset mid-operation: assert `rst_n`=0 between edges while `out_valid`=1 -> `out_valid` and all outputs go to 0 immediately, with no output transfer after release until a new input.
